// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared state encoding, counter width and data width default.
package dmem_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b10} state_t;
  localparam int CNT_W = 4;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/dmem_responder_array.sv
// dmem_array: single-port word storage, falling-edge write and registered read, no reset.
module dmem_array #(
  parameter int IW = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**IW];
  always_ff @(negedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with configurable wait states, Stall and RespValid.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT = 2
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              MemoryRead,
  input  logic              MemoryWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              RespValid,
  output logic              Err
);
  localparam int IW = ADDR_W - 2;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic l_rd, l_wr, err_q, err_n, rd_ok, perf, lat_req, stall, we, re;
  logic [ADDR_W-1:0] l_addr, cur_addr;
  logic [DATA_W-1:0] l_wdata, cur_wdata, rdata;
  logic cur_rd, cur_wr;
  wire req = MemoryRead | MemoryWrite;
  // The request cycle itself is the first stall cycle, so WAIT lasts LAT-1 cycles.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    stall = 1'b0;
    perf = 1'b0;
    lat_req = 1'b0;
    case (state)
      IDLE: begin
        stall = req && LAT != 0;
        if (req && LAT <= 1) begin
          perf = 1'b1;
          state_n = DONE;
        end else if (req) begin
          lat_req = 1'b1;
          cnt_n = CNT_W'(LAT - 2);
          state_n = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == '0) begin
          perf = 1'b1;
          state_n = DONE;
        end else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    cur_rd = state == IDLE ? MemoryRead : l_rd;
    cur_wr = state == IDLE ? MemoryWrite : l_wr;
    cur_addr = state == IDLE ? Address : l_addr;
    cur_wdata = state == IDLE ? WriteData : l_wdata;
    we = perf & cur_wr & Reset_L;
    re = perf & cur_rd & ~cur_wr & Reset_L;
    err_n = perf & ((cur_rd & cur_wr) | (cur_addr[1:0] != 2'b00));
  end
  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= IDLE;
      cnt <= '0;
      err_q <= 1'b0;
      rd_ok <= 1'b0;
      l_rd <= 1'b0;
      l_wr <= 1'b0;
      l_addr <= '0;
      l_wdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      err_q <= err_n;
      rd_ok <= rd_ok | re;
      if (lat_req) begin
        l_rd <= MemoryRead;
        l_wr <= MemoryWrite;
        l_addr <= Address;
        l_wdata <= WriteData;
      end
    end
  end
  dmem_array #(.IW(IW), .DATA_W(DATA_W)) u_array (
    .clk(CLK), .we(we), .re(re), .idx(cur_addr[ADDR_W-1:2]), .wdata(cur_wdata), .rdata(rdata)
  );
  // The array read register has no reset, so ReadData reads zero until a read lands.
  assign ReadData = rd_ok ? rdata : '0;
  assign Stall = stall & Reset_L;
  assign RespValid = state == DONE;
  assign Err = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on LAT=2, LAT=0 and LAT=3 instances of dmem_responder.
module tb_dmem_responder;
  logic CLK = 1'b0;
  logic Reset_L;
  logic mr [3];
  logic mw [3];
  logic [5:0] addr [3];
  logic [31:0] wd [3];
  logic [31:0] rdd [3];
  logic st [3];
  logic rv [3];
  logic er [3];
  int n_chk = 0;
  int n_fail = 0;
  always #5 CLK = ~CLK;
  dmem_responder #(.ADDR_W(6), .DATA_W(32), .LAT(2)) dut0 (
    .CLK(CLK), .Reset_L(Reset_L), .MemoryRead(mr[0]), .MemoryWrite(mw[0]), .Address(addr[0]),
    .WriteData(wd[0]), .ReadData(rdd[0]), .Stall(st[0]), .RespValid(rv[0]), .Err(er[0]));
  dmem_responder #(.ADDR_W(6), .DATA_W(32), .LAT(0)) dut1 (
    .CLK(CLK), .Reset_L(Reset_L), .MemoryRead(mr[1]), .MemoryWrite(mw[1]), .Address(addr[1]),
    .WriteData(wd[1]), .ReadData(rdd[1]), .Stall(st[1]), .RespValid(rv[1]), .Err(er[1]));
  dmem_responder #(.ADDR_W(6), .DATA_W(32), .LAT(3)) dut2 (
    .CLK(CLK), .Reset_L(Reset_L), .MemoryRead(mr[2]), .MemoryWrite(mw[2]), .Address(addr[2]),
    .WriteData(wd[2]), .ReadData(rdd[2]), .Stall(st[2]), .RespValid(rv[2]), .Err(er[2]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Called just after a rising edge; returns at the rising edge of the following IDLE cycle.
  task automatic access(input int i, input int lat, input bit r, input bit w, input logic [5:0] a,
                        input logic [31:0] d, input bit e, input bit rchk, input logic [31:0] exp_rd,
                        input bit tog);
    int nreq = lat == 0 ? 1 : lat;
    mr[i] = r;
    mw[i] = w;
    addr[i] = a;
    wd[i] = d;
    for (int c = 0; c < nreq; c++) begin
      #1;
      chk($sformatf("stall[%0d] c%0d", i, c), 32'(st[i]), 32'(lat != 0));
      chk($sformatf("rv_early[%0d] c%0d", i, c), 32'(rv[i]), 32'd0);
      @(posedge CLK);
      if (tog) begin
        addr[i] = addr[i] ^ 6'h04;
        wd[i] = ~wd[i];
      end
    end
    #1;
    chk($sformatf("rv[%0d]", i), 32'(rv[i]), 32'd1);
    chk($sformatf("stall_done[%0d]", i), 32'(st[i]), 32'd0);
    chk($sformatf("err[%0d]", i), 32'(er[i]), 32'(e));
    if (rchk) chk($sformatf("rdata[%0d] @%h", i, a), rdd[i], exp_rd);
    mr[i] = 1'b0;
    mw[i] = 1'b0;
    @(posedge CLK);
    #1;
    chk($sformatf("rv_idle[%0d]", i), 32'(rv[i]), 32'd0);
    chk($sformatf("err_idle[%0d]", i), 32'(er[i]), 32'd0);
    @(posedge CLK);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      mr[i] = 1'b0;
      mw[i] = 1'b0;
      addr[i] = '0;
      wd[i] = '0;
    end
    Reset_L = 1'b0;
    mr[0] = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_stall", 32'(st[0]), 32'd0);
    chk("reset_rv", 32'(rv[0]), 32'd0);
    chk("reset_err", 32'(er[0]), 32'd0);
    chk("reset_rdata", rdd[0], 32'd0);
    mr[0] = 1'b0;
    @(posedge CLK);
    Reset_L = 1'b1;
    access(0, 2, 0, 1, 6'h08, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    access(0, 2, 1, 0, 6'h08, 32'h0, 0, 1, 32'hDEADBEEF, 0);
    for (int k = 0; k < 16; k++) begin
      access(1, 0, 0, 1, 6'(k * 4), 32'hC0DE0000 | 32'(k * 257), 0, 0, 32'h0, 0);
      access(1, 0, 1, 0, 6'(k * 4), 32'h0, 0, 1, 32'hC0DE0000 | 32'(k * 257), 0);
    end
    access(0, 2, 1, 1, 6'h04, 32'h12345678, 1, 1, 32'hDEADBEEF, 0);
    access(0, 2, 1, 0, 6'h04, 32'h0, 0, 1, 32'h12345678, 0);
    access(0, 2, 0, 1, 6'h04, 32'hA5A5A5A5, 0, 0, 32'h0, 0);
    access(0, 2, 1, 0, 6'h06, 32'h0, 1, 1, 32'hA5A5A5A5, 0);
    access(2, 3, 0, 1, 6'h24, 32'h22222222, 0, 0, 32'h0, 0);
    access(2, 3, 0, 1, 6'h20, 32'h11111111, 0, 0, 32'h0, 1);
    access(2, 3, 1, 0, 6'h20, 32'h0, 0, 1, 32'h11111111, 0);
    access(2, 3, 1, 0, 6'h24, 32'h0, 0, 1, 32'h22222222, 0);
    access(0, 2, 0, 1, 6'h10, 32'h55555555, 0, 0, 32'h0, 0);
    access(0, 2, 1, 0, 6'h10, 32'h0, 0, 1, 32'h55555555, 0);
    mw[0] = 1'b1;
    addr[0] = 6'h10;
    wd[0] = 32'hBAD0BAD0;
    @(posedge CLK);
    #1;
    chk("wait_stall", 32'(st[0]), 32'd1);
    Reset_L = 1'b0;
    #1;
    chk("abort_stall", 32'(st[0]), 32'd0);
    chk("abort_rv", 32'(rv[0]), 32'd0);
    chk("abort_rdata", rdd[0], 32'd0);
    mw[0] = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_rv_next", 32'(rv[0]), 32'd0);
    @(posedge CLK);
    Reset_L = 1'b1;
    access(0, 2, 1, 0, 6'h10, 32'h0, 0, 1, 32'h55555555, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
